fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Write-side scheduler for the async FIFO: shares the single winc/wdata port among NREQ producers in wclk domain.
//  Round-robin grant, programmable burst length and inter-burst idle gap (write throttling), stalls on wfull.
//  Sits directly in front of Asynchronous_FIFO write port; datapath is combinational, control is sequential.
// PARAMETERS
//  DSIZE    8  data width, matches FIFO DSIZE
//  NREQ     4  number of requesters (2..16)
//  BURST_W  4  width of burst_len config
//  GAP_W    4  width of gap_cycles config
// PORTS
//  wclk        in   1           write-domain clock
//  wrst        in   1           asynchronous reset, active-high
//  req         in   NREQ        requester i has valid data
//  req_data    in   NREQ*DSIZE  flattened; requester i at [i*DSIZE +: DSIZE]
//  gnt         out  NREQ        one-hot ready; transfer when req[i]&gnt[i] at wclk edge
//  wfull       in   1           FIFO full flag
//  winc        out  1           FIFO write enable
//  wdata       out  DSIZE       FIFO write data
//  burst_len   in   BURST_W     max beats per grant; 0 treated as 1
//  gap_cycles  in   GAP_W       idle cycles after each non-empty burst
//  owner       out  clog2(NREQ) current/last granted requester (registered)
//  busy        out  1           state != IDLE
// BEHAVIOUR
//  - States IDLE, GRANT, GAP. Regs: cur, last, beat_cnt, gap_cnt, latched burst/gap.
//  - Reset (async, any time incl. mid-burst): state=IDLE, cur=owner=0, last=NREQ-1, counters 0; gnt=0, winc=0, busy=0.
//  - gnt[i] = (state==GRANT) & (cur==i) & !wfull. winc = |(req&gnt). wdata = req_data[cur] (comb, zero latency).
//  - Arbitration point: search from last+1 upward with wrap; first req set wins -> cur=last=winner, GRANT,
//    beat_cnt=0, burst_len/gap_cycles latched. No req -> IDLE.
//  - IDLE: arbitration point every cycle. First gnt one cycle after req seen.
//  - GRANT: on transfer beat_cnt++; burst ends when beat_cnt+1==burst_len at transfer edge.
//    req[cur] low at an edge without transfer ends burst early.
//  - End of burst with >=1 beat: gap>0 -> GAP, gap_cnt=gap; gap==0 -> arbitration point at that edge.
//    End with 0 beats: arbitration point, no gap.
//  - wfull in GRANT: gnt low, no beat counted, cur held, no timeout.
//  - GAP: gap_cnt decrements; last GAP cycle (gap_cnt==1) is an arbitration point.
//  - Spacing: burst_len=1, gap=G -> writes every G+1 cycles under continuous req.
//  - Config changes mid-burst ignored until next arbitration point.
//  - Never asserts winc while wfull=1; never more than one gnt bit set.
// CONFIGURATION
//  FIFO_WR_ARB_STATS_EN defined: adds ports stat_clr (in,1), wr_count (out,16), stall_count (out,16).
//    wr_count +1 per winc; stall_count +1 per GRANT cycle with wfull=1 and req[cur]=1.
//    Both wrap at 16 bits; cleared by wrst or stat_clr (clear wins over increment).
//  Not defined: those ports and counters absent; all other behaviour identical.
// TESTING
//  1 wrst held then released, req=0 -> gnt=0, winc=0, busy=0, owner=0 for 10 cycles.
//  2 req=4'b0001, burst_len=1, gap=3, wfull=0 -> winc every 4th cycle, wdata=req_data[0].
//  3 req=4'b1111, burst_len=2, gap=0 -> owner sequence 0,1,2,3,0; 2 beats each, no idle cycles between bursts.
//  4 req=4'b0011, burst_len=4, wfull high 3 cycles mid-burst -> gnt low 3 cycles; burst resumes with cur=0; 4 beats total.
//  5 assert wrst mid-burst (beat 2 of 4) -> same-cycle winc=0, gnt=0, state IDLE; after release first grant goes to req 0.
//  6 STATS_EN: 20 writes + 5 full stalls -> wr_count=20, stall_count=5; stat_clr pulse -> both 0 next cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Write-side round-robin scheduler in front of the async FIFO write port: burst/gap throttling, stalls on wfull.
// Optional FIFO_WR_ARB_STATS_EN adds stat_clr, wr_count and stall_count.
module fifo_wr_arbiter #(
    parameter int DSIZE   = 8,
    parameter int NREQ    = 4,
    parameter int BURST_W = 4,
    parameter int GAP_W   = 4,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    input  logic [BURST_W-1:0]    burst_len,
    input  logic [GAP_W-1:0]      gap_cycles,
    output logic [IW-1:0]         owner,
`ifdef FIFO_WR_ARB_STATS_EN
    input  logic                  stat_clr,
    output logic [15:0]           wr_count,
    output logic [15:0]           stall_count,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state;
    logic [IW-1:0]      cur, last;
    logic [BURST_W-1:0] beat_cnt, burst_lat, eff_len;
    logic [GAP_W-1:0]   gap_cnt, gap_lat;

    logic               found;
    logic [IW-1:0]      win, idx;
    logic               last_beat, early_end, burst_end, go_gap, arb_pt;

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            gnt[i] = (state == GRANT) && (cur == IW'(i)) && !wfull;
    end

    assign winc  = |(req & gnt);
    assign wdata = req_data[cur*DSIZE +: DSIZE];
    assign owner = cur;
    assign busy  = (state != IDLE);

    // Walk downward so the requester closest after 'last' is the final (winning) assignment.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        eff_len   = (burst_lat == '0) ? BURST_W'(1) : burst_lat;
        last_beat = winc && (({1'b0, beat_cnt} + (BURST_W+1)'(1)) == {1'b0, eff_len});
        early_end = (state == GRANT) && !winc && !req[cur];
        burst_end = (state == GRANT) && (last_beat || early_end);
        // A burst that moved zero beats skips the idle gap.
        go_gap    = burst_end && (last_beat || beat_cnt != '0) && (gap_lat != '0);
        arb_pt    = (state == IDLE) || (burst_end && !go_gap) ||
                    ((state == GAP) && (gap_cnt == GAP_W'(1)));
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state     <= IDLE;
            cur       <= '0;
            last      <= IW'(NREQ-1);
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            burst_lat <= '0;
            gap_lat   <= '0;
        end else if (arb_pt) begin
            gap_cnt <= '0;
            if (found) begin
                state     <= GRANT;
                cur       <= win;
                last      <= win;
                beat_cnt  <= '0;
                burst_lat <= burst_len;
                gap_lat   <= gap_cycles;
            end else begin
                state <= IDLE;
            end
        end else if (go_gap) begin
            state   <= GAP;
            gap_cnt <= gap_lat;
        end else if (state == GRANT && winc) begin
            beat_cnt <= beat_cnt + BURST_W'(1);
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else if (stat_clr) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (winc)
                wr_count <= wr_count + 16'd1;
            if (state == GRANT && wfull && req[cur])
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

    a_no_write_when_full: assert property (@(posedge wclk) disable iff (wrst) !(winc && wfull));
    a_gnt_onehot0:        assert property (@(posedge wclk) disable iff (wrst) $onehot0(gnt));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized run against a behavioural model.
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DSIZE = 8;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  burst_len;
    logic [3:0]  gap_cycles;
    logic [1:0]  owner;
    logic        busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] wr_count, stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter dut (
        .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .gnt(gnt),
        .wfull(wfull), .winc(winc), .wdata(wdata), .burst_len(burst_len),
        .gap_cycles(gap_cycles), .owner(owner),
`ifdef FIFO_WR_ARB_STATS_EN
        .stat_clr(stat_clr), .wr_count(wr_count), .stall_count(stall_count),
`endif
        .busy(busy)
    );

    // Behavioural model: who holds the grant (-1 none), beats moved, idle cycles left.
    int m_cur, m_last, m_gto, m_rest, m_done, m_lim, m_glat;

    task automatic model_reset();
        m_cur = 0; m_last = NREQ-1; m_gto = -1; m_rest = 0; m_done = 0; m_lim = 1; m_glat = 0;
    endtask

    task automatic model_arb();
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (req[j]) begin
                m_gto = j; m_cur = j; m_last = j; m_done = 0;
                m_lim = (burst_len == 0) ? 1 : int'(burst_len);
                m_glat = int'(gap_cycles);
                return;
            end
        end
    endtask

    task automatic model_step();
        bit w;
        w = (m_gto >= 0) && !wfull && req[m_gto];
        if (m_gto < 0 && m_rest == 0) begin
            model_arb();
        end else if (m_gto >= 0) begin
            if (w) m_done++;
            if ((w && m_done == m_lim) || (!w && !req[m_gto])) begin
                m_gto = -1;
                if (m_done > 0 && m_glat > 0) m_rest = m_glat;
                else model_arb();
            end
        end else begin
            if (m_rest == 1) begin m_rest = 0; model_arb(); end
            else m_rest--;
        end
    endtask

    task automatic do_reset();
        wrst = 1'b1; req = '0; wfull = 1'b0; req_data = '0;
`ifdef FIFO_WR_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        @(posedge wclk); @(posedge wclk); #1;
        wrst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        burst_len = 4'd1; gap_cycles = 4'd0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #2;
            n_checks++;
            if (gnt !== 4'b0 || winc !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got gnt=%b winc=%b busy=%b owner=%0d exp 0/0/0/0", c, gnt, winc, busy, owner);
            end
            @(posedge wclk); #1;
        end
    endtask

    task automatic test_burst_spacing();
        do_reset();
        req = 4'b0001; burst_len = 4'd1; gap_cycles = 4'd3;
        for (int c = 0; c < 20; c++) begin
            logic ew;
            req_data = $urandom;
            #2;
            ew = (c >= 1) && ((c - 1) % 4 == 0);
            n_checks++;
            if (winc !== ew) begin
                n_fail++;
                $display("FAIL spacing_winc c=%0d got=%b exp=%b", c, winc, ew);
            end
            if (ew) begin
                n_checks++;
                if (wdata !== req_data[7:0]) begin
                    n_fail++;
                    $display("FAIL spacing_wdata c=%0d got=%h exp=%h", c, wdata, req_data[7:0]);
                end
            end
            @(posedge wclk); #1;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111; burst_len = 4'd2; gap_cycles = 4'd0;
        for (int c = 0; c < 11; c++) begin
            int eo;
            logic [3:0] eg;
            req_data = $urandom;
            #2;
            eo = (c == 0) ? 0 : ((c - 1) / 2) % 4;
            eg = (c == 0) ? 4'b0 : 4'(1 << eo);
            n_checks++;
            if (gnt !== eg || winc !== (c != 0) || owner !== 2'(eo)) begin
                n_fail++;
                $display("FAIL rr c=%0d got gnt=%b winc=%b owner=%0d exp gnt=%b owner=%0d", c, gnt, winc, owner, eg, eo);
            end
            @(posedge wclk); #1;
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req = 4'b0011; burst_len = 4'd4; gap_cycles = 4'd0;
        for (int c = 0; c < 9; c++) begin
            logic [3:0] eg;
            wfull = (c >= 2 && c <= 4);
            #2;
            if (c == 0 || wfull) eg = 4'b0000;
            else if (c == 8)     eg = 4'b0010;
            else                 eg = 4'b0001;
            n_checks++;
            if (gnt !== eg || winc !== (eg != 0)) begin
                n_fail++;
                $display("FAIL full_stall c=%0d got gnt=%b winc=%b exp gnt=%b", c, gnt, winc, eg);
            end
            if (c >= 1 && c <= 7) begin
                n_checks++;
                if (owner !== 2'd0) begin
                    n_fail++;
                    $display("FAIL full_stall_owner c=%0d got=%0d exp=0", c, owner);
                end
            end
            @(posedge wclk); #1;
        end
        wfull = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0011; burst_len = 4'd4; gap_cycles = 4'd0;
        @(posedge wclk); #1;
        @(posedge wclk); #1;
        #2;
        n_checks++;
        if (winc !== 1'b1 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_beat2 got winc=%b owner=%0d exp 1/0", winc, owner);
        end
        wrst = 1'b1;
        #1;
        n_checks++;
        if (winc !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_async got winc=%b gnt=%b busy=%b owner=%0d exp 0/0/0/0", winc, gnt, busy, owner);
        end
        @(posedge wclk); @(posedge wclk); #1;
        wrst = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL midrst_idle got gnt=%b exp 0000", gnt);
        end
        @(posedge wclk); #3;
        n_checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_first got gnt=%b owner=%0d exp 0001/0", gnt, owner);
        end
        @(posedge wclk); #1;
    endtask

    task automatic test_random();
        do_reset();
        burst_len = 4'd2; gap_cycles = 4'd1;
        for (int c = 0; c < 800; c++) begin
            logic [3:0] eg;
            logic       ew;
            if ($urandom_range(0, 7) == 0) burst_len  = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) gap_cycles = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            wfull    = ($urandom_range(0, 3) == 0);
            req_data = $urandom;
            #2;
            eg = (m_gto >= 0 && !wfull) ? 4'(1 << m_gto) : 4'b0;
            ew = (m_gto >= 0) && !wfull && req[m_gto];
            n_checks++;
            if (gnt !== eg || winc !== ew) begin
                n_fail++;
                $display("FAIL rand_gnt c=%0d got gnt=%b winc=%b exp gnt=%b winc=%b", c, gnt, winc, eg, ew);
            end
            n_checks++;
            if (owner !== 2'(m_cur) || busy !== (m_gto >= 0 || m_rest > 0)) begin
                n_fail++;
                $display("FAIL rand_state c=%0d got owner=%0d busy=%b exp owner=%0d busy=%b", c, owner, busy, m_cur, (m_gto >= 0 || m_rest > 0));
            end
            n_checks++;
            if (wdata !== req_data[m_cur*8 +: 8]) begin
                n_fail++;
                $display("FAIL rand_wdata c=%0d got=%h exp=%h", c, wdata, req_data[m_cur*8 +: 8]);
            end
            @(posedge wclk);
            model_step();
            #1;
        end
        req = '0; wfull = 1'b0;
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats();
        int nw;
        nw = 0;
        do_reset();
        req = 4'b0001; burst_len = 4'd4; gap_cycles = 4'd0;
        for (int c = 0; c < 100 && nw < 20; c++) begin
            wfull = (c >= 3 && c < 8);
            #2;
            if (winc) nw++;
            @(posedge wclk); #1;
        end
        wfull = 1'b0;
        n_checks++;
        if (nw != 20 || wr_count !== 16'd20 || stall_count !== 16'd5) begin
            n_fail++;
            $display("FAIL stats_count writes=%0d got wr=%0d stall=%0d exp 20/5", nw, wr_count, stall_count);
        end
        stat_clr = 1'b1;
        @(posedge wclk); #1;
        stat_clr = 1'b0;
        n_checks++;
        if (wr_count !== 16'd0 || stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_clr got wr=%0d stall=%0d exp 0/0", wr_count, stall_count);
        end
    endtask
`endif

    initial begin
        wrst = 1'b1; req = '0; req_data = '0; wfull = 1'b0;
        burst_len = 4'd1; gap_cycles = 4'd0;
`ifdef FIFO_WR_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        test_reset();
        test_burst_spacing();
        test_round_robin();
        test_full_stall();
        test_reset_mid_burst();
        test_random();
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
